// File: rtl/spi_ctrl_pkg.sv
// Shared state encoding and width helper for the SPI master arbiter.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, GAP} spi_arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after (ptr+1) mod NUM_REQ.
module rr_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  ptr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [idx_width(NUM_REQ)-1:0]  gnt_idx,
  output logic                           any
);

  localparam int IW = idx_width(NUM_REQ);

  int            idx;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      sel = IW'(idx);
      if (!found && req[sel]) begin
        found    = 1'b1;
        gnt[sel] = 1'b1;
        gnt_idx  = sel;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sharing of one SPI master among NUM_REQ requesters, with a
// completion watchdog and a CS-high gap between transactions.
module spi_master_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int PAYLOAD_BITS   = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int GAP_CYCLES     = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  input  logic [NUM_REQ-1:0]              rsp_ready,
  output logic [PAYLOAD_BITS-1:0]         rsp_data,
  output logic                            rsp_err,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            busy,
  output logic                            spi_en,
  output logic                            spi_transmit_en,
  output logic [PAYLOAD_BITS-1:0]         spi_mosi_data,
  input  logic [PAYLOAD_BITS-1:0]         spi_miso_data,
  input  logic                            spi_payload_done,
  output logic                            spi_rst
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  spi_arb_state_t          state_q, state_d;
  logic [IW-1:0]           ptr_q, ptr_d;
  logic [IW-1:0]           grant_id_q, grant_id_d;
  logic [PAYLOAD_BITS-1:0] mosi_q, mosi_d;
  logic [PAYLOAD_BITS-1:0] rsp_data_q, rsp_data_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    transmit_en_q, transmit_en_d;
  logic                    spi_rst_q, spi_rst_d;
  logic                    spi_en_q, spi_en_d;
  logic                    busy_q, busy_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [GW-1:0]           gap_q, gap_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IW-1:0]           arb_idx;
  logic                    arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // req_ready is the only combinational output: the accept must land in the grant cycle.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_id_d    = grant_id_q;
    mosi_d        = mosi_q;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_err_d     = rsp_err_q;
    transmit_en_d = 1'b0;
    spi_rst_d     = 1'b0;
    timer_d       = timer_q;
    gap_d         = gap_q;
    req_ready     = '0;
    unique case (state_q)
      IDLE: begin
        if (!rst && enable && arb_any) begin
          req_ready     = arb_gnt;
          mosi_d        = req_data[arb_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
          grant_id_d    = arb_idx;
          ptr_d         = arb_idx;
          transmit_en_d = 1'b1;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (spi_payload_done) begin
          rsp_data_d              = spi_miso_data;
          rsp_err_d               = 1'b0;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = RESP;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          rsp_data_d              = '0;
          rsp_err_d               = 1'b1;
          spi_rst_d               = 1'b1;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = RESP;
        end else if (timer_q != {TW{1'b1}}) begin
          timer_d = timer_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready[grant_id_q]) begin
          rsp_valid_d = '0;
          gap_d       = '0;
          state_d     = (GAP_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                              gap_d   = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    spi_en_d = enable;
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= IW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      mosi_q        <= '0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= 1'b0;
      transmit_en_q <= 1'b0;
      spi_rst_q     <= 1'b0;
      spi_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      timer_q       <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      mosi_q        <= mosi_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      transmit_en_q <= transmit_en_d;
      spi_rst_q     <= spi_rst_d;
      spi_en_q      <= spi_en_d;
      busy_q        <= busy_d;
      timer_q       <= timer_d;
      gap_q         <= gap_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign grant_id        = grant_id_q;
  assign busy            = busy_q;
  assign spi_en          = spi_en_q;
  assign spi_transmit_en = transmit_en_q;
  assign spi_mosi_data   = mosi_q;
  assign spi_rst         = spi_rst_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a behavioural SPI slave model.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready = '0;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [1:0]  grant_id;
  logic        busy;
  logic        spi_en;
  logic        spi_transmit_en;
  logic [7:0]  spi_mosi_data;
  logic [7:0]  spi_miso_data = '0;
  logic        spi_payload_done = 1'b0;
  logic        spi_rst;

  int testsRun = 0;
  int failCount = 0;

  logic       slave_on = 1'b0;
  int         slave_delay = 3;
  logic [7:0] slave_word = '0;
  int         slave_cnt = 0;
  int         txCount = 0;

  spi_master_arbiter #(
    .NUM_REQ(4), .PAYLOAD_BITS(8), .TIMEOUT_CYCLES(16), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy), .spi_en(spi_en),
    .spi_transmit_en(spi_transmit_en), .spi_mosi_data(spi_mosi_data),
    .spi_miso_data(spi_miso_data), .spi_payload_done(spi_payload_done), .spi_rst(spi_rst)
  );

  always #5 clk = ~clk;

  // Slave model: answers slave_delay cycles after the transmit_en pulse with slave_word.
  always @(negedge clk) begin
    spi_payload_done = 1'b0;
    if (slave_cnt > 0) begin
      slave_cnt = slave_cnt - 1;
      if (slave_cnt == 0) begin
        spi_payload_done = 1'b1;
        spi_miso_data    = slave_word;
      end
    end
    if (spi_transmit_en) begin
      txCount = txCount + 1;
      if (slave_on) slave_cnt = slave_delay;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed still running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [31:0] d);
    req_valid = v;
    req_data  = d;
    #1;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    stepCycles(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic waitRsp(input string tag, output int n);
    n = 0;
    while (rsp_valid == 4'b0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_rsp_seen"}, 32'(rsp_valid != 4'b0), 32'd1);
  endtask

  task automatic waitGrant(input string tag, output int n);
    n = 0;
    while (req_ready == 4'b0 && n < 64) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_grant_seen"}, 32'(req_ready != 4'b0), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] d [4];
    d = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset values
    stepCycles(3);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_outs", {rsp_valid, req_ready, grant_id, spi_transmit_en, spi_rst, rsp_err, spi_en},
                32'd0);
    checkOutput("rst_data", {rsp_data, spi_mosi_data}, 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    stepCycles(2);

    // Single request
    slave_on = 1'b1; slave_delay = 3; slave_word = 8'h3C;
    applyStimulus(4'b0001, 32'h443322A5);
    checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("t1_tx_en", 32'(spi_transmit_en), 32'd1);
    checkOutput("t1_mosi", 32'(spi_mosi_data), 32'hA5);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    waitRsp("t1", n);
    checkOutput("t1_latency", 32'(n), 32'd4);
    checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("t1_rsp_data", 32'(rsp_data), 32'h3C);
    checkOutput("t1_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("t1_tx_count", 32'(txCount), 32'd1);
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    checkOutput("t1_rsp_clear", {rsp_valid, 3'b0, busy}, {4'h0, 3'b0, 1'b1});
    stepCycles(2);
    checkOutput("t1_idle", 32'(busy), 32'd0);

    // Contention from reset: grants 0,1,2,3,0 with a 2-cycle gap each
    doReset();
    slave_delay = 2;
    rsp_ready = 4'b1111;
    applyStimulus(4'b1111, {d[3], d[2], d[1], d[0]});
    for (int i = 0; i < 5; i++) begin
      slave_word = 8'hC0 + 8'(i);
      waitGrant("t2", n);
      if (i > 0) checkOutput("t2_gap", 32'(n), 32'd3);
      checkOutput("t2_grant", 32'(req_ready), 32'(4'b0001 << (i % 4)));
      @(negedge clk);
      checkOutput("t2_grant_id", 32'(grant_id), 32'(i % 4));
      checkOutput("t2_mosi", 32'(spi_mosi_data), 32'(d[i % 4]));
      waitRsp("t2", n);
      checkOutput("t2_rsp", {rsp_valid, rsp_data}, {4'b0001 << (i % 4), 8'hC0 + 8'(i)});
    end
    applyStimulus(4'b0000, 32'h0);
    stepCycles(3);
    rsp_ready = 4'b0000;
    checkOutput("t2_idle", 32'(busy), 32'd0);

    // Timeout on requester 2
    slave_on = 1'b0;
    applyStimulus(4'b0100, 32'h00770000);
    checkOutput("t3_req_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("t3_tx_en", 32'(spi_transmit_en), 32'd1);
    n = 0;
    while (!spi_rst && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t3_spi_rst_delay", 32'(n), 32'd17);
    checkOutput("t3_rsp", {rsp_valid, rsp_err, rsp_data}, {4'b0100, 1'b1, 8'h00});
    @(negedge clk);
    checkOutput("t3_rst_pulse", {spi_rst, rsp_valid}, {1'b0, 4'b0100});
    rsp_ready = 4'b1011;
    @(negedge clk);
    checkOutput("t3_other_ready", 32'(rsp_valid), 32'h4);
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'b0000;
    checkOutput("t3_rsp_clear", 32'(rsp_valid), 32'h0);
    stepCycles(2);

    // Backpressure on requester 3 with requester 1 pending
    slave_on = 1'b1; slave_delay = 2; slave_word = 8'h9E;
    applyStimulus(4'b1010, 32'hD300B100);
    checkOutput("t4_req_ready", 32'(req_ready), 32'h8);
    @(negedge clk);
    applyStimulus(4'b0010, 32'hD300B100);
    waitRsp("t4", n);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_hold", {rsp_valid, rsp_data, req_ready, busy}, {4'b1000, 8'h9E, 4'b0000, 1'b1});
      @(negedge clk);
    end
    rsp_ready = 4'b1000;
    @(negedge clk);
    rsp_ready = 4'b0000;
    slave_word = 8'h61;
    waitGrant("t4", n);
    checkOutput("t4_next_gap", 32'(n), 32'd2);
    checkOutput("t4_next_grant", 32'(req_ready), 32'h2);
    @(negedge clk);
    applyStimulus(4'b0000, 32'h0);
    waitRsp("t4b", n);
    checkOutput("t4_rsp1", {rsp_valid, rsp_data}, {4'b0010, 8'h61});
    rsp_ready = 4'b0010;
    @(negedge clk);
    rsp_ready = 4'b0000;
    stepCycles(2);

    // enable dropped during WAIT with requester 2 pending
    slave_delay = 3; slave_word = 8'h5C;
    applyStimulus(4'b0001, 32'h0000000F);
    checkOutput("t5_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    enable = 1'b0;
    applyStimulus(4'b0100, 32'h002A0000);
    checkOutput("t5_tx_en", 32'(spi_transmit_en), 32'd1);
    waitRsp("t5", n);
    checkOutput("t5_rsp", {rsp_valid, rsp_data}, {4'b0001, 8'h5C});
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = 4'b0000;
    stepCycles(5);
    checkOutput("t5_stalled", {req_ready, busy, spi_en}, 32'd0);
    enable = 1'b1;
    #1;
    checkOutput("t5_resume", 32'(req_ready), 32'h4);
    @(negedge clk);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("t5_grant2", {grant_id, spi_mosi_data}, {2'd2, 8'h2A});
    waitRsp("t5b", n);
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = 4'b0000;
    stepCycles(2);

    // Reset in WAIT with requesters 0 and 3 pending
    slave_on = 1'b0;
    applyStimulus(4'b0100, 32'hD0E700A0);
    checkOutput("t6_req_ready", 32'(req_ready), 32'h4);
    @(negedge clk);
    applyStimulus(4'b1101, 32'hD0E700A0);
    stepCycles(3);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_outs", {rsp_valid, req_ready, grant_id, spi_transmit_en, spi_rst, rsp_err, spi_en, busy},
                32'd0);
    checkOutput("t6_rst_data", {rsp_data, spi_mosi_data}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("t6_first_grant", 32'(req_ready), 32'h1);
    @(negedge clk);
    applyStimulus(4'b0000, 32'h0);
    checkOutput("t6_grant_id", {grant_id, spi_mosi_data}, {2'd0, 8'hA0});

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
